// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer for the Program1 core
//
// Owns the PC and sequences fetch: start, linear increment, taken branches
// through the branch-target LUT, stall and halt. Optional watchdog under the
// PC_SEQ_WDOG_EN macro.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   start        begin program (honored in IDLE or DONE)
//   stall        freeze PC and counters this cycle
//   halt         current instruction is halt
//   branch_en    current instruction is a conditional branch
//   branch_cond  branch condition flag
//   branch_idx   LUT index field of current instruction
//   lut_index    to LUT, combinational copy of branch_idx
//   lut_target   LUT output (branch target PC)
//   pc           current PC
//   run          high in RUN
//   done         high in DONE
//   retired      saturating retired-instruction count
//   wdog_trip    watchdog ended the run (0 when PC_SEQ_WDOG_EN is undefined)
module pc_sequencer #(
    parameter int PC_W       = 7,
    parameter int IDX_W      = 6,
    parameter int START_PC   = 0,
    parameter int WDOG_LIMIT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_en,
    input  logic             branch_cond,
    input  logic [IDX_W-1:0] branch_idx,
    output logic [IDX_W-1:0] lut_index,
    input  logic [PC_W-1:0]  lut_target,
    output logic [PC_W-1:0]  pc,
    output logic             run,
    output logic             done,
    output logic [15:0]      retired,
    output logic             wdog_trip
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [PC_W-1:0] W_START = PC_W'(START_PC);

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [15:0]     r_retired, w_retired_nxt;
    logic [15:0]     w_retired_inc;
    logic            w_wdog_hit;

    // Saturating increment: the count sticks at all-ones.
    assign w_retired_inc = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;

`ifdef PC_SEQ_WDOG_EN
    localparam int WD_W = ($clog2(WDOG_LIMIT + 1) > 10) ? $clog2(WDOG_LIMIT + 1) : 10;

    // r_wdog_cnt holds the number of RUN cycles already completed in this run,
    // so the hit fires during the WDOG_LIMIT-th RUN cycle.
    logic [WD_W-1:0] r_wdog_cnt, w_wdog_cnt_nxt;
    logic            r_wdog_trip, w_wdog_trip_nxt;

    assign w_wdog_hit = (r_state == S_RUN) && (r_wdog_cnt >= WD_W'(WDOG_LIMIT - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= W_START;
            r_retired   <= 16'd0;
`ifdef PC_SEQ_WDOG_EN
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_retired   <= w_retired_nxt;
`ifdef PC_SEQ_WDOG_EN
            r_wdog_cnt  <= w_wdog_cnt_nxt;
            r_wdog_trip <= w_wdog_trip_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_retired_nxt = r_retired;
`ifdef PC_SEQ_WDOG_EN
        w_wdog_trip_nxt = r_wdog_trip;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt   = S_RUN;
                    w_pc_nxt      = W_START;
                    w_retired_nxt = 16'd0;
`ifdef PC_SEQ_WDOG_EN
                    w_wdog_trip_nxt = 1'b0;
`endif
                end
            end
            S_RUN: begin
                // An unstalled halt in the watchdog cycle still counts as a
                // clean halt; any other watchdog cycle ends the run without
                // retiring anything.
                if (w_wdog_hit && !(halt && !stall)) begin
                    w_state_nxt = S_DONE;
`ifdef PC_SEQ_WDOG_EN
                    w_wdog_trip_nxt = 1'b1;
`endif
                end else if (stall) begin
                    w_state_nxt = S_RUN;
                end else if (halt) begin
                    w_state_nxt   = S_DONE;
                    w_retired_nxt = w_retired_inc;
                end else if (branch_en && branch_cond) begin
                    w_pc_nxt      = lut_target;
                    w_retired_nxt = w_retired_inc;
                end else begin
                    w_pc_nxt      = r_pc + PC_W'(1);
                    w_retired_nxt = w_retired_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef PC_SEQ_WDOG_EN
    // Cleared on entry to RUN, counts every RUN cycle including stalls.
    always_comb begin
        w_wdog_cnt_nxt = r_wdog_cnt;
        if (r_state != S_RUN && w_state_nxt == S_RUN) begin
            w_wdog_cnt_nxt = '0;
        end else if (r_state == S_RUN) begin
            w_wdog_cnt_nxt = r_wdog_cnt + WD_W'(1);
        end
    end
`endif

    // Outputs
    always_comb begin
        lut_index = branch_idx;
        pc        = r_pc;
        retired   = r_retired;
        run       = (r_state == S_RUN);
        done      = (r_state == S_DONE);
`ifdef PC_SEQ_WDOG_EN
        wdog_trip = r_wdog_trip;
`else
        wdog_trip = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
module tb_pc_sequencer;

    localparam int PC_W  = 7;
    localparam int IDX_W = 6;
    localparam int WDL   = 20;

    logic             clk = 1'b0;
    logic             reset, start, stall, halt, branch_en, branch_cond;
    logic [IDX_W-1:0] branch_idx, lut_index;
    logic [PC_W-1:0]  lut_target, pc;
    logic             run, done, wdog_trip;
    logic [15:0]      retired;

    logic [PC_W-1:0]  lut_mem [64];

    always #5 clk = ~clk;

    assign lut_target = lut_mem[lut_index];

    pc_sequencer #(
        .PC_W(PC_W), .IDX_W(IDX_W), .START_PC(0), .WDOG_LIMIT(WDL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch_en(branch_en), .branch_cond(branch_cond), .branch_idx(branch_idx),
        .lut_index(lut_index), .lut_target(lut_target), .pc(pc), .run(run),
        .done(done), .retired(retired), .wdog_trip(wdog_trip)
    );

    typedef struct packed {
        logic [6:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] ret;
        logic        trip;
        logic [31:0] n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;

    // Reference model: mode 0=idle 1=running 2=finished
    int m_mode = 0, m_pc = 0, m_ret = 0, m_runcyc = 0;
    bit m_trip = 0;
    bit wd_en;

    initial begin
`ifdef PC_SEQ_WDOG_EN
        wd_en = 1'b1;
`else
        wd_en = 1'b0;
`endif
    end

    task automatic model_step();
        bit expired;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_ret = 0; m_trip = 0; m_runcyc = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = 0; m_ret = 0; m_trip = 0; m_runcyc = 0;
            end
        end else begin
            m_runcyc = m_runcyc + 1;
            expired  = wd_en && (m_runcyc >= WDL);
            if (!stall && halt) begin
                m_mode = 2;
                if (m_ret < 65535) m_ret = m_ret + 1;
            end else if (expired) begin
                m_mode = 2; m_trip = 1;
            end else if (!stall) begin
                if (branch_en && branch_cond) m_pc = lut_mem[branch_idx];
                else                          m_pc = (m_pc + 1) % 128;
                if (m_ret < 65535) m_ret = m_ret + 1;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input bit sl, input bit h,
                       input bit be, input bit bc, input int idx);
        exp_t e;
        @(negedge clk);
        reset = rst; start = st; stall = sl; halt = h;
        branch_en = be; branch_cond = bc; branch_idx = IDX_W'(idx);
        #1;
        checks++;
        if (lut_index !== IDX_W'(idx)) begin
            errors++;
            $display("FAIL lut_index step %0d got %0d want %0d", step_n, lut_index, idx);
        end
        model_step();
        e.pc   = m_pc[6:0];
        e.run  = (m_mode == 1);
        e.done = (m_mode == 2);
        e.ret  = m_ret[15:0];
        e.trip = m_trip;
        e.n    = step_n;
        q.push_back(e);
        step_n++;
    endtask

    task automatic norm(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, $urandom_range(0, 63));
    endtask

    task automatic br(input int idx);
        cyc(0, 0, 0, 0, 1, 1, idx);
    endtask

    // Monitor: outputs are valid every cycle after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks += 5;
            if (pc !== e.pc) begin
                errors++;
                $display("FAIL pc step %0d got %0d want %0d", e.n, pc, e.pc);
            end
            if (run !== e.run) begin
                errors++;
                $display("FAIL run step %0d got %0b want %0b", e.n, run, e.run);
            end
            if (done !== e.done) begin
                errors++;
                $display("FAIL done step %0d got %0b want %0b", e.n, done, e.done);
            end
            if (retired !== e.ret) begin
                errors++;
                $display("FAIL retired step %0d got %0d want %0d", e.n, retired, e.ret);
            end
            if (wdog_trip !== e.trip) begin
                errors++;
                $display("FAIL wdog_trip step %0d got %0b want %0b", e.n, wdog_trip, e.trip);
            end
        end
    end

    initial begin
        reset = 1; start = 0; stall = 0; halt = 0;
        branch_en = 0; branch_cond = 0; branch_idx = '0;
        for (int i = 0; i < 64; i++) lut_mem[i] = PC_W'($urandom_range(0, 127));
        lut_mem[1] = 7;  lut_mem[5] = 19; lut_mem[2] = 126;
        lut_mem[6] = 40; lut_mem[7] = 22; lut_mem[4] = 26;

        // Reset with start held high, then idle
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Start, ten linear instructions
        cyc(0, 1, 0, 0, 0, 0, 0);
        norm(10);
        // Taken and not-taken branch at pc 7
        br(1); br(5);
        br(1); cyc(0, 0, 0, 0, 1, 0, 5);
        // Wrap from 126
        br(2); norm(2);
        // Stall at 40 with halt/branch asserted underneath
        br(6);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 1, 5);
        norm(1);
        // halt beats branch, then restart from DONE
        cyc(0, 0, 0, 1, 1, 1, 5);
        cyc(0, 0, 0, 0, 1, 1, 5);
        cyc(0, 1, 0, 0, 0, 0, 0);
        // start ignored in RUN, reset mid-run at pc 22 with start high
        br(7);
        cyc(0, 1, 0, 0, 0, 0, 0);
        br(7);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Branch-to-self: watchdog trips after WDL cycles if enabled
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (101) br(4);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Watchdog with stalls mixed in
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (30) cyc(0, 0, $urandom_range(0, 1), 0, 0, 0, 0);

        // Randomized traffic
        repeat (3000) begin
            cyc(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                ($urandom % 20) == 0, $urandom % 2, $urandom % 2,
                $urandom_range(0, 63));
        end

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
